// File: rtl/mips_prog_loader.sv
// Program-memory loader: assembles a length-prefixed, XOR-checksummed byte stream
// into 32-bit big-endian words and writes them sequentially to program memory.
// The CPU is held in reset until the load completes with a good checksum.
module mips_prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_pm_we,
  output logic [15:0] o_pm_addr,
  output logic [31:0] o_pm_wdata,
  output logic        o_cpu_reset,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t      r_state, w_next;
  logic        r_byte_ready, r_pm_we, r_cpu_reset, r_done, r_error;
  logic [15:0] r_pm_addr, r_len, r_cnt;
  logic [31:0] r_shift;
  logic [7:0]  r_len_hi, r_csum;
  logic [1:0]  r_bcnt;

  logic        w_xfer, w_start_ok, w_len_bad;
  logic [15:0] w_len, w_cnt_next;

  // byte_ready is a flop, so a transfer never depends combinationally on itself
  assign w_xfer     = i_byte_valid & r_byte_ready;
  assign w_start_ok = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_len      = {r_len_hi, i_byte_in};
  assign w_len_bad  = (w_len == 16'd0) || ({1'b0, w_len} > LP_MAX);
  assign w_cnt_next = r_cnt + 16'd1;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_start) w_next = S_LEN_HI;
      S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO: if (w_xfer) w_next = w_len_bad ? S_ERR : S_WORD;
      S_WORD:   if (w_xfer && (r_bcnt == 2'd3)) w_next = S_WRITE;
      S_WRITE:  w_next = (w_cnt_next == r_len) ? S_CSUM : S_WORD;
      S_CSUM:   if (w_xfer) w_next = (i_byte_in == r_csum) ? S_DONE : S_ERR;
      S_DONE:   if (i_start) w_next = S_LEN_HI;
      S_ERR:    if (i_start) w_next = S_LEN_HI;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state; datapath updates per current state
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_byte_ready <= 1'b0;
      r_pm_we      <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_pm_addr    <= BASE_ADDR;
      r_shift      <= 32'd0;
      r_len_hi     <= 8'd0;
      r_len        <= 16'd0;
      r_cnt        <= 16'd0;
      r_csum       <= 8'd0;
      r_bcnt       <= 2'd0;
    end else begin
      r_byte_ready <= (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                      (w_next == S_WORD)   || (w_next == S_CSUM);
      r_pm_we      <= (w_next == S_WRITE);
      r_cpu_reset  <= (w_next != S_DONE);
      r_done       <= (w_next == S_DONE);
      r_error      <= (w_next == S_ERR);
      if (w_start_ok) begin
        r_pm_addr <= BASE_ADDR;
        r_cnt     <= 16'd0;
        r_csum    <= 8'd0;
        r_bcnt    <= 2'd0;
      end
      if (w_xfer && (r_state == S_LEN_HI)) r_len_hi <= i_byte_in;
      if (w_xfer && (r_state == S_LEN_LO)) r_len <= w_len;
      if (w_xfer && (r_state == S_WORD)) begin
        r_shift <= {r_shift[23:0], i_byte_in};
        r_csum  <= r_csum ^ i_byte_in;
        r_bcnt  <= r_bcnt + 2'd1;
      end
      // Address advances on the cycle after the write strobe
      if (r_state == S_WRITE) begin
        r_pm_addr <= r_pm_addr + 16'd1;
        r_cnt     <= w_cnt_next;
      end
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_pm_we      = r_pm_we;
  assign o_pm_addr    = r_pm_addr;
  assign o_pm_wdata   = r_shift;
  assign o_cpu_reset  = r_cpu_reset;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: directed byte streams; expected program-memory
// writes go into a scoreboard queue and a negedge monitor checks each pm_we.
// A second instance with MAX_WORDS=4 shares the stimulus for the length limit.
module tb_mips_prog_loader;

  logic        clk, rst, start, valid;
  logic [7:0]  bin;
  logic        o_byte_ready, o_pm_we, o_cpu_reset, o_done, o_error;
  logic [15:0] o_pm_addr;
  logic [31:0] o_pm_wdata;
  logic        w4_ready, w4_we, w4_cpu_reset, w4_done, w4_error;
  logic [15:0] w4_addr;
  logic [31:0] w4_wdata;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] strm[$];
  int         n_chk = 0;
  int         n_pass = 0;

  mips_prog_loader dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_byte_in(bin),
    .i_byte_valid(valid), .o_byte_ready(o_byte_ready), .o_pm_we(o_pm_we),
    .o_pm_addr(o_pm_addr), .o_pm_wdata(o_pm_wdata), .o_cpu_reset(o_cpu_reset),
    .o_done(o_done), .o_error(o_error)
  );

  mips_prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_byte_in(bin),
    .i_byte_valid(valid), .o_byte_ready(w4_ready), .o_pm_we(w4_we),
    .o_pm_addr(w4_addr), .o_pm_wdata(w4_wdata), .o_cpu_reset(w4_cpu_reset),
    .o_done(w4_done), .o_error(w4_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst && o_pm_we) begin
      check("ready_low_in_write", {31'd0, o_byte_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {16'd0, o_pm_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {16'd0, o_pm_addr}, {16'd0, e.a});
        check("wr_data", o_pm_wdata, e.d);
      end
    end
  end

  task automatic push_nominal();
    exp_q.push_back('{a: 16'h0000, d: 32'h8C22_0004});
    exp_q.push_back('{a: 16'h0001, d: 32'h0043_0820});
  endtask

  task automatic set_nominal();
    strm = '{8'h00, 8'h02, 8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h43, 8'h08, 8'h20, 8'hC1};
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it
  task automatic send_byte(input logic [7:0] b);
    int n;
    bin   = b;
    valid = 1'b1;
    n     = 0;
    while (1) begin
      @(negedge clk);
      if (o_byte_ready) break;
      n++;
      if (n > 40) begin
        check("byte_accept_timeout", 32'd0, 32'd1);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_stream(input bit bubble);
    foreach (strm[i]) begin
      send_byte(strm[i]);
      if (bubble) begin
        valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; bin = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_ready", {31'd0, o_byte_ready}, 32'd0);
    check("rst_pm_we",      {31'd0, o_pm_we}, 32'd0);
    check("rst_pm_addr",    {16'd0, o_pm_addr}, 32'd0);
    check("rst_pm_wdata",   o_pm_wdata, 32'd0);
    check("rst_cpu_reset",  {31'd0, o_cpu_reset}, 32'd1);
    check("rst_done",       {31'd0, o_done}, 32'd0);
    check("rst_error",      {31'd0, o_error}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal load, valid held high
    push_nominal();
    set_nominal();
    do_start();
    send_stream(1'b0);
    check("nom_done",      {31'd0, o_done}, 32'd1);
    check("nom_error",     {31'd0, o_error}, 32'd0);
    check("nom_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);
    check("nom_addr_end",  {16'd0, o_pm_addr}, 32'd2);
    check("nom_dut4_done", {31'd0, w4_done}, 32'd1);

    // Reload from DONE: cpu_reset rises on the start edge
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("reload_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    check("reload_addr",      {16'd0, o_pm_addr}, 32'd0);
    check("reload_done_clr",  {31'd0, o_done}, 32'd0);
    check("reload_ready",     {31'd0, o_byte_ready}, 32'd1);
    // Second load uses valid bubbles
    push_nominal();
    set_nominal();
    send_stream(1'b1);
    check("bubble_done",      {31'd0, o_done}, 32'd1);
    check("bubble_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);

    // Bad checksum
    push_nominal();
    set_nominal();
    strm[10] = 8'hC0;
    do_start();
    send_stream(1'b0);
    check("badcs_error",     {31'd0, o_error}, 32'd1);
    check("badcs_done",      {31'd0, o_done}, 32'd0);
    check("badcs_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);

    // Zero length goes straight to ERR with no write
    strm = '{8'h00, 8'h00};
    do_start();
    send_stream(1'b0);
    check("len0_error", {31'd0, o_error}, 32'd1);
    check("len0_ready", {31'd0, o_byte_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("len0_error_sticky", {31'd0, o_error}, 32'd1);

    // Length 5: rejected with MAX_WORDS=4, accepted with the default limit
    strm = '{8'h00, 8'h05};
    do_start();
    send_stream(1'b0);
    check("len5_max4_error",  {31'd0, w4_error}, 32'd1);
    check("len5_dflt_error",  {31'd0, o_error}, 32'd0);
    check("len5_dflt_ready",  {31'd0, o_byte_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset after 6 bytes (first word written) aborts the load
    exp_q.push_back('{a: 16'h0000, d: 32'h8C22_0004});
    strm = '{8'h00, 8'h02, 8'h8C, 8'h22, 8'h00, 8'h04};
    do_start();
    send_stream(1'b0);
    @(posedge clk); #1;
    check("mid_addr_before", {16'd0, o_pm_addr}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_addr",      {16'd0, o_pm_addr}, 32'd0);
    check("mid_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    check("mid_ready",     {31'd0, o_byte_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_nominal();
    set_nominal();
    do_start();
    send_stream(1'b0);
    check("restart_done",      {31'd0, o_done}, 32'd1);
    check("restart_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Program-memory writer for the 16-bit MIPS pipeline: the load-side counterpart of the program memory block, which only ever reads instructions. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. It writes them sequentially into program memory while holding the CPU in reset, then releases the CPU once the load completes and the checksum verifies.

## Interface
- BASE_ADDR, 16'h0000: program-memory word address of the first instruction written
- MAX_WORDS, 1024: largest accepted instruction count
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  begin a load; honoured only in IDLE, DONE or ERR
- byte_in  input  8  stream byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts byte_in this cycle
- pm_we  output  1  program-memory write strobe, one cycle per instruction
- pm_addr  output  16  program-memory word address
- pm_wdata  output  32  instruction word
- cpu_reset  output  1  hold for the CPU pipeline reset
- done  output  1  load finished with a good checksum
- error  output  1  load aborted due to bad length or checksum mismatch

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N×4 instruction bytes (MSB first), then 1 checksum byte equal to the XOR of all instruction bytes (length bytes excluded).
- A byte transfers on a rising edge when byte_valid && byte_ready. byte_ready is high only in LEN_HI, LEN_LO, WORD and CSUM. byte_valid without byte_ready has no effect.
- States:
  - IDLE -> LEN_HI on start.
  - LEN_HI -> LEN_LO after 1 transfer.
  - LEN_LO -> ERR if N==0 or N>MAX_WORDS; otherwise WORD.
  - WORD collects 4 bytes into a shift register, then -> WRITE.
  - WRITE lasts 1 cycle and asserts pm_we. It then goes -> WORD if words remain, otherwise -> CSUM.
  - CSUM -> DONE on checksum match, otherwise -> ERR, after 1 transfer.
  - DONE and ERR are sticky; start -> LEN_HI from either.
- pm_addr = BASE_ADDR at load start and increments by 1 on the cycle after each pm_we. pm_wdata holds the assembled word and is valid while pm_we=1.
- The running checksum is an 8-bit XOR, cleared at load start and updated on every WORD-state transfer.
- cpu_reset is 1 in every state except DONE. It reasserts on the same edge that takes DONE -> LEN_HI.
- done=1 only in DONE; error=1 only in ERR. Both clear on the edge leaving those states.
- start while in LEN_HI..CSUM is ignored.
- Program memory is written only via pm_we. The CPU reads it only after cpu_reset drops, so no read/write arbitration is needed.

## Timing
- Reset values:
  - state IDLE, byte_ready 0, pm_we 0, pm_addr BASE_ADDR, pm_wdata 0.
  - cpu_reset 1, done 0, error 0, checksum 0, word counter 0.
- reset asserted mid-load aborts immediately to IDLE. Partially written memory is not cleaned up.
- Latency:
  - The 4th byte of an instruction is accepted at edge k. pm_we is high for cycle k..k+1 (registered). byte_ready is low during that cycle.
  - Sustained throughput is 1 word per 5 cycles with byte_valid held high.
- Checksum byte accepted at edge k: done/error and cpu_reset update at edge k, i.e. visible in the following cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs, byte_ready included.
- Word counter is 16 bits. N=MAX_WORDS is legal; the last address is BASE_ADDR+MAX_WORDS-1, with no wrap inside the legal range.
- byte_valid gaps (bubbles) stall the FSM with no loss of state.

## Test plan
- Nominal load: start, then bytes 00 02 8C 22 00 04 00 43 08 20 C1 with valid held high.
  - Expect pm_we at addr 0x0000 with data 0x8C220004.
  - Expect pm_we at addr 0x0001 with data 0x00430820.
  - Expect done=1, error=0, cpu_reset=0 afterwards.
- Bad checksum: same stream with final byte C0.
  - Expect both writes to occur, then error=1, done=0, cpu_reset=1.
- Length checks:
  - Bytes 00 00 -> ERR right after LEN_LO, with no pm_we.
  - With MAX_WORDS=4, bytes 00 05 -> ERR.
- Handshake bubbles: nominal stream with byte_valid toggling 1/0 every cycle.
  - Expect identical writes and done.
  - Expect byte_ready=0 during each WRITE cycle, and no byte consumed then.
- Reset mid-load: assert reset after 6 bytes of the nominal stream.
  - Expect IDLE, cpu_reset=1 and pm_addr=BASE_ADDR.
  - A full restart then completes normally.
- Reload from DONE: issue start again.
  - Expect cpu_reset to rise on the same edge, pm_addr to return to BASE_ADDR, done to clear, and a second load to succeed.
